// File: rtl/qam16_mapper_upsampler_if.sv
// Bit-stream input and I/Q sample output bundle for the 16-QAM mapper/upsampler.
interface qam16_mapper_upsampler_if #(
    parameter int DATA_WIDTH = 12
);
    logic                         clear;
    logic                         bit_in;
    logic                         bit_valid;
    logic                         bit_ready;
    logic                         sample_en;
    logic signed [DATA_WIDTH-1:0] i_out;
    logic signed [DATA_WIDTH-1:0] q_out;
    logic                         out_valid;
    logic                         sym_strobe;
    logic                         underflow;

    modport master (
        output clear, bit_in, bit_valid, sample_en,
        input  bit_ready, i_out, q_out, out_valid, sym_strobe, underflow
    );

    modport slave (
        input  clear, bit_in, bit_valid, sample_en,
        output bit_ready, i_out, q_out, out_valid, sym_strobe, underflow
    );
endinterface

// File: rtl/qam16_mapper_upsampler.sv
// Packs serial bits into 16-QAM symbols, maps each axis to Q1.11 levels and
// emits a zero-stuffed stream at SPS samples per symbol.
module qam16_axis_map #(
    parameter int DATA_WIDTH = 12,
    parameter int GRAY_EN    = 1
) (
    input  logic [1:0]                   code,
    output logic signed [DATA_WIDTH-1:0] level
);
    logic [1:0] rank;

    // Gray codes 00,01,11,10 are ranked 0..3 in ascending amplitude.
    assign rank = (GRAY_EN != 0) ? {code[1], code[1] ^ code[0]} : code;

    always_comb begin
        level = '0;
        case (rank)
            2'd0: level = DATA_WIDTH'(-1943);
            2'd1: level = DATA_WIDTH'(-648);
            2'd2: level = DATA_WIDTH'(648);
            2'd3: level = DATA_WIDTH'(1943);
            default: level = '0;
        endcase
    end
endmodule

module qam16_mapper_upsampler #(
    parameter int DATA_WIDTH = 12,
    parameter int SPS        = 4,
    parameter int GRAY_EN    = 1
) (
    input logic                     clk,
    input logic                     rst_n,
    qam16_mapper_upsampler_if.slave bus
);
    localparam int PW = $clog2(SPS);

    logic [1:0]    cnt;
    logic [3:0]    asm_sr;
    logic [3:0]    buf_sym;
    logic          buf_full;
    logic [PW-1:0] phase;
    logic          ph0;
    logic          consume;
    logic          xfer;
    logic          last;
    logic [1:0][DATA_WIDTH-1:0] lvl;

    for (genvar ax = 0; ax < 2; ax++) begin : g_axis
        qam16_axis_map #(.DATA_WIDTH(DATA_WIDTH), .GRAY_EN(GRAY_EN)) u_map (
            .code  (buf_sym[2*ax +: 2]),
            .level (lvl[ax])
        );
    end

    assign ph0           = (phase == '0);
    assign consume       = bus.sample_en && ph0 && buf_full;
    // A full buffer only stalls the final bit of the next nibble.
    assign bus.bit_ready = (cnt != 2'd3) || !buf_full || consume;
    assign xfer          = bus.bit_valid && bus.bit_ready && !bus.clear;
    assign last          = xfer && (cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            asm_sr         <= '0;
            buf_sym        <= '0;
            buf_full       <= 1'b0;
            phase          <= '0;
            bus.i_out      <= '0;
            bus.q_out      <= '0;
            bus.out_valid  <= 1'b0;
            bus.sym_strobe <= 1'b0;
            bus.underflow  <= 1'b0;
        end else if (bus.clear) begin
            cnt            <= '0;
            buf_full       <= 1'b0;
            phase          <= '0;
            bus.i_out      <= '0;
            bus.q_out      <= '0;
            bus.out_valid  <= 1'b0;
            bus.sym_strobe <= 1'b0;
            bus.underflow  <= 1'b0;
        end else begin
            if (xfer) begin
                asm_sr <= {asm_sr[2:0], bus.bit_in};
                cnt    <= cnt + 2'd1;
            end
            // A reload on the same cycle as consume keeps the buffer full.
            if (last) begin
                buf_sym  <= {asm_sr[2:0], bus.bit_in};
                buf_full <= 1'b1;
            end else if (consume) begin
                buf_full <= 1'b0;
            end

            bus.out_valid  <= bus.sample_en;
            bus.sym_strobe <= bus.sample_en && ph0;
            if (bus.sample_en) begin
                phase     <= (phase == PW'(SPS - 1)) ? '0 : phase + PW'(1);
                bus.i_out <= consume ? lvl[1] : '0;
                bus.q_out <= consume ? lvl[0] : '0;
                if (ph0 && !buf_full)
                    bus.underflow <= 1'b1;
            end
        end
    end
endmodule
